c1_serial_addsub: RTL and testbench

- Parametrised, digit-serial ones'-complement (C1) adder/subtractor with start/done handshake.
- Adds D bits per clock and applies the end-around carry as a second serial pass, only when needed.
- Extends the combinational C1 adder with:
  - configurable width and digit size;
  - subtract mode;
  - signed-overflow flag;
  - optional negative-zero normalisation.
- Serves as the area-cheap arithmetic unit for the lab datapath.

---
 rtl/c1_serial_addsub_if.sv | 24 ++
 rtl/c1_serial_addsub.sv | 125 ++++++++++++
 tb/tb_c1_serial_addsub.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/c1_serial_addsub_if.sv
// rtl/c1_serial_addsub_if.sv - start/done request and result bundle for c1_serial_addsub
interface c1_serial_addsub_if #(
  parameter int W = 8
);
  logic         i_start;
  logic         i_sub;
  logic         i_ci;
  logic [W-1:0] i_x;
  logic [W-1:0] i_y;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_z;
  logic         o_ovf;

  modport master (
    output i_start, i_sub, i_ci, i_x, i_y,
    input  o_busy, o_done, o_z, o_ovf
  );

  modport slave (
    input  i_start, i_sub, i_ci, i_x, i_y,
    output o_busy, o_done, o_z, o_ovf
  );
endinterface

// File: rtl/c1_serial_addsub.sv
// rtl/c1_serial_addsub.sv - digit-serial ones'-complement adder/subtractor
// PASS1 forms the raw sum; PASS2 re-runs the same digit adder to fold in the end-around carry.
module c1_serial_addsub #(
  parameter int W         = 8,
  parameter int D         = 2,
  parameter int NORM_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  c1_serial_addsub_if.slave bus
);
  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_xa;
  logic [W-1:0] r_yb;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_z;
  logic         r_ovf;
  logic         r_carry;
  logic         r_xs;
  logic         r_ys;
  logic [CW-1:0] r_cnt;

  logic [D:0]   w_dsum;
  logic [W-1:0] w_acc_next;
  logic [W-1:0] w_z_norm;
  logic         w_ovf;
  logic         w_last;
  logic         w_eac;

  assign w_dsum = {1'b0, r_xa[D-1:0]} + {1'b0, r_yb[D-1:0]} + {{D{1'b0}}, r_carry};
  assign w_eac  = w_dsum[D];
  assign w_last = (r_cnt == LAST);

  generate
    if (W > D) begin : g_shift
      assign w_acc_next = {w_dsum[D-1:0], r_acc[W-1:D]};
    end else begin : g_single
      assign w_acc_next = w_dsum[D-1:0];
    end
  endgenerate

  // Overflow uses the pre-normalisation sign, so negative zero still reports correctly.
  assign w_ovf    = (r_xs == r_ys) && (w_acc_next[W-1] != r_xs);
  assign w_z_norm = ((NORM_ZERO != 0) && (&w_acc_next)) ? '0 : w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_PASS1;
      S_PASS1: if (w_last) w_next = w_eac ? S_PASS2 : S_DONE;
      S_PASS2: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xa    <= '0;
      r_yb    <= '0;
      r_acc   <= '0;
      r_z     <= '0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_xs    <= 1'b0;
      r_ys    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_xa    <= bus.i_x;
            r_yb    <= bus.i_sub ? ~bus.i_y : bus.i_y;
            r_xs    <= bus.i_x[W-1];
            r_ys    <= bus.i_sub ? ~bus.i_y[W-1] : bus.i_y[W-1];
            r_carry <= bus.i_ci;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_PASS1, S_PASS2: begin
          r_acc   <= w_acc_next;
          r_xa    <= r_xa >> D;
          r_yb    <= r_yb >> D;
          r_carry <= w_eac;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            if (r_state == S_PASS1 && w_eac) begin
              // Raw sum becomes the x operand of the second pass; y is zero.
              r_xa    <= w_acc_next;
              r_yb    <= '0;
              r_carry <= 1'b1;
            end else begin
              r_z   <= w_z_norm;
              r_ovf <= w_ovf;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_busy = (r_state == S_PASS1) || (r_state == S_PASS2);
  assign bus.o_done = (r_state == S_DONE);
  assign bus.o_z    = r_z;
  assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_c1_serial_addsub.sv
// tb/tb_c1_serial_addsub.sv - self-checking bench for c1_serial_addsub
module tb_c1_serial_addsub;
  localparam int LMAX = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  c1_serial_addsub_if #(.W(8))  a8 ();
  c1_serial_addsub_if #(.W(8))  a8n ();
  c1_serial_addsub_if #(.W(4))  a4 ();
  c1_serial_addsub_if #(.W(16)) a16 ();

  c1_serial_addsub #(.W(8),  .D(2), .NORM_ZERO(0)) u8   (.clk(clk), .rst(rst), .bus(a8.slave));
  c1_serial_addsub #(.W(8),  .D(2), .NORM_ZERO(1)) u8n  (.clk(clk), .rst(rst), .bus(a8n.slave));
  c1_serial_addsub #(.W(4),  .D(1), .NORM_ZERO(0)) u4   (.clk(clk), .rst(rst), .bus(a4.slave));
  c1_serial_addsub #(.W(16), .D(4), .NORM_ZERO(0)) u16  (.clk(clk), .rst(rst), .bus(a16.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: integer sum, end-around carry added once, any second carry dropped.
  function automatic void c1_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input bit sub, input bit ci, input bit norm,
                                   output logic [31:0] z, output bit ovf, output bit eac);
    longint unsigned mask, xx, yb, s, r;
    mask = (64'd1 << w) - 1;
    xx   = {32'd0, x} & mask;
    yb   = sub ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    s    = xx + yb + (ci ? 1 : 0);
    eac  = ((s >> w) & 1) == 1;
    r    = ((s & mask) + (eac ? 1 : 0)) & mask;
    ovf  = (((xx >> (w-1)) & 1) == ((yb >> (w-1)) & 1)) &&
           (((r >> (w-1)) & 1) != ((xx >> (w-1)) & 1));
    if (norm && r == mask) r = 0;
    z = r[31:0];
  endfunction

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit sub, input bit ci);
    logic [31:0] ez, ezn;
    bit eo, eon, eac, eacn;
    int lat, bz;
    c1_model(8, {24'd0, x}, {24'd0, y}, sub, ci, 1'b0, ez, eo, eac);
    c1_model(8, {24'd0, x}, {24'd0, y}, sub, ci, 1'b1, ezn, eon, eacn);
    @(negedge clk);
    a8.i_x = x;  a8.i_y = y;  a8.i_sub = sub;  a8.i_ci = ci;  a8.i_start = 1'b1;
    a8n.i_x = x; a8n.i_y = y; a8n.i_sub = sub; a8n.i_ci = ci; a8n.i_start = 1'b1;
    @(posedge clk); #1;
    a8.i_start = 1'b0; a8n.i_start = 1'b0;
    lat = 1; bz = 0;
    while (a8.o_done !== 1'b1 && lat < LMAX) begin
      if (a8.o_busy === 1'b1) bz++;
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", lat, eac ? 9 : 5);
    chk("w8_busy_cycles", bz, eac ? 8 : 4);
    chk("w8_busy_at_done", a8.o_busy, 1'b0);
    chk("w8_z", a8.o_z, ez);
    chk("w8_ovf", a8.o_ovf, eo);
    chk("w8n_done", a8n.o_done, 1'b1);
    chk("w8n_z", a8n.o_z, ezn);
    chk("w8n_ovf", a8n.o_ovf, eon);
    @(posedge clk); #1;
    chk("w8_done_pulse", a8.o_done, 1'b0);
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input bit sub, input bit ci);
    logic [31:0] ez;
    bit eo, eac;
    int lat;
    c1_model(4, {28'd0, x}, {28'd0, y}, sub, ci, 1'b0, ez, eo, eac);
    @(negedge clk);
    a4.i_x = x; a4.i_y = y; a4.i_sub = sub; a4.i_ci = ci; a4.i_start = 1'b1;
    @(posedge clk); #1;
    a4.i_start = 1'b0;
    lat = 1;
    while (a4.o_done !== 1'b1 && lat < LMAX) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w4_latency", lat, eac ? 9 : 5);
    chk("w4_z", a4.o_z, ez);
    chk("w4_ovf", a4.o_ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y, input bit sub, input bit ci);
    logic [31:0] ez;
    bit eo, eac;
    int lat;
    c1_model(16, {16'd0, x}, {16'd0, y}, sub, ci, 1'b0, ez, eo, eac);
    @(negedge clk);
    a16.i_x = x; a16.i_y = y; a16.i_sub = sub; a16.i_ci = ci; a16.i_start = 1'b1;
    @(posedge clk); #1;
    a16.i_start = 1'b0;
    lat = 1;
    while (a16.o_done !== 1'b1 && lat < LMAX) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_latency", lat, eac ? 9 : 5);
    chk("w16_z", a16.o_z, ez);
    chk("w16_ovf", a16.o_ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [7:0] zcap;
    a8.i_start = 0;  a8.i_sub = 0;  a8.i_ci = 0;  a8.i_x = 0;  a8.i_y = 0;
    a8n.i_start = 0; a8n.i_sub = 0; a8n.i_ci = 0; a8n.i_x = 0; a8n.i_y = 0;
    a4.i_start = 0;  a4.i_sub = 0;  a4.i_ci = 0;  a4.i_x = 0;  a4.i_y = 0;
    a16.i_start = 0; a16.i_sub = 0; a16.i_ci = 0; a16.i_x = 0; a16.i_y = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", a8.o_busy, 1'b0);
    chk("rst_done", a8.o_done, 1'b0);
    chk("rst_z", a8.o_z, 8'h00);
    chk("rst_ovf", a8.o_ovf, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run8(8'h05, 8'h03, 1'b0, 1'b0);
    chk("plain_z_const", a8.o_z, 8'h08);
    run8(8'h05, 8'hFC, 1'b0, 1'b0);
    chk("eac_z_const", a8.o_z, 8'h02);
    run8(8'h05, 8'h05, 1'b1, 1'b0);
    chk("negzero_z_const", a8.o_z, 8'hFF);
    chk("negzero_norm_const", a8n.o_z, 8'h00);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    chk("ovf_z_const", a8.o_z, 8'h80);
    chk("ovf_flag_const", a8.o_ovf, 1'b1);
    run8(8'hFF, 8'hFF, 1'b0, 1'b1);
    chk("dblcarry_z_const", a8.o_z, 8'h00);
    chk("dblcarry_ovf_const", a8.o_ovf, 1'b1);

    // Second start mid-PASS1 with different operands must be ignored.
    @(negedge clk);
    a8.i_x = 8'h05; a8.i_y = 8'h03; a8.i_sub = 1'b0; a8.i_ci = 1'b0; a8.i_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a8.i_x = 8'h7F; a8.i_y = 8'h01; a8.i_sub = 1'b1; a8.i_ci = 1'b1;
    dones = 0; zcap = 8'h00;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 1) a8.i_start = 1'b0;
      if (a8.o_done === 1'b1) begin
        dones++;
        zcap = a8.o_z;
      end
    end
    chk("midstart_done_count", dones, 1);
    chk("midstart_z", zcap, 8'h08);

    // Reset in PASS2 abandons the operation.
    @(negedge clk);
    a8.i_x = 8'h05; a8.i_y = 8'hFC; a8.i_sub = 1'b0; a8.i_ci = 1'b0; a8.i_start = 1'b1;
    @(posedge clk); #1;
    a8.i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pass2_busy", a8.o_busy, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", a8.o_busy, 1'b0);
    chk("rst_mid_z", a8.o_z, 8'h00);
    chk("rst_mid_ovf", a8.o_ovf, 1'b0);
    chk("rst_mid_done", a8.o_done, 1'b0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a8.o_done === 1'b1) dones++;
    end
    chk("rst_mid_no_done", dones, 0);
    run8(8'h05, 8'h03, 1'b0, 1'b0);
    chk("after_rst_z_const", a8.o_z, 8'h08);

    for (int i = 0; i < 200; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    for (int xi = 0; xi < 16; xi++)
      for (int yi = 0; yi < 16; yi++)
        for (int m = 0; m < 4; m++)
          run4(4'(xi), 4'(yi), m[1], m[0]);

    for (int i = 0; i < 2000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
